// File: rtl/sd_pkg.sv
// Shared SD definitions used by both the read and the write paths:
// block size, writer FSM encoding and the read-path selector encoding.
package sd_pkg;

  localparam int BLOCK_BYTES = 512;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_REQUEST   = 3'd2,
    ST_STREAM    = 3'd3,
    ST_WAIT_DONE = 3'd4
  } writer_state_t;

  // Read-path source selector encoding.
  localparam logic [1:0] SEL_DIR     = 2'd0;
  localparam logic [1:0] SEL_CLUSTER = 2'd1;
  localparam logic [1:0] SEL_DATA    = 2'd2;

  // A requested block count of zero still writes one block.
  function automatic logic [15:0] blocks_or_one(input logic [15:0] n);
    return (n == 16'd0) ? 16'd1 : n;
  endfunction

endpackage

// File: rtl/sd_block_writer.sv
// Streams bytes from an FWFT FIFO into the SD controller's single-block
// write interface, one 512-byte sector at a time, zero-padding a final
// partial block on flush and flagging FIFO underruns.
module sd_block_writer #(
  parameter int         BLOCK_BYTES = 512,
  parameter logic [7:0] PAD_BYTE    = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] sector_addr,
  input  logic [15:0] n_blocks,
  input  logic        flush,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  input  logic [9:0]  fifo_count,
  output logic        fifo_rd_en,
  input  logic        sd_ready,
  input  logic        sd_ready_for_next_byte,
  output logic        sd_wr,
  output logic [31:0] sd_addr,
  output logic [7:0]  sd_din,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic [15:0] blocks_written
);
  import sd_pkg::*;

  localparam logic [9:0] FULL_COUNT = 10'(BLOCK_BYTES);
  localparam logic [9:0] LAST_IDX   = 10'(BLOCK_BYTES - 1);

  writer_state_t state_q, state_d;
  logic [31:0]   sd_addr_q, sd_addr_d;
  logic [15:0]   blocks_left_q, blocks_left_d;
  logic [15:0]   blocks_written_q, blocks_written_d;
  logic [9:0]    data_bytes_q, data_bytes_d;
  logic [9:0]    byte_idx_q, byte_idx_d;
  logic          underrun_q, underrun_d;
  logic          sd_wr_q, sd_wr_d;
  logic          done_q, done_d;
  logic          sd_ready_q;

  logic in_data_s;
  logic streaming_s;

  // Byte-level datapath: present the FIFO head (or padding) and pop on the pulse.
  always_comb begin
    streaming_s = (state_q == ST_STREAM);
    in_data_s   = (byte_idx_q < data_bytes_q);
    fifo_rd_en  = streaming_s && sd_ready_for_next_byte && in_data_s && !fifo_empty;
    if (streaming_s && in_data_s && !fifo_empty) begin
      sd_din = fifo_data;
    end else begin
      sd_din = PAD_BYTE;
    end
  end

  // Next-state and counter updates for the block-write sequencer.
  always_comb begin
    state_d          = state_q;
    sd_addr_d        = sd_addr_q;
    blocks_left_d    = blocks_left_q;
    blocks_written_d = blocks_written_q;
    data_bytes_d     = data_bytes_q;
    byte_idx_d       = byte_idx_q;
    underrun_d       = underrun_q;
    sd_wr_d          = 1'b0;
    done_d           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sd_addr_d        = sector_addr;
          blocks_left_d    = blocks_or_one(n_blocks);
          underrun_d       = 1'b0;
          blocks_written_d = 16'd0;
          state_d          = ST_WAIT_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_DATA: begin
        if (fifo_count >= FULL_COUNT) begin
          data_bytes_d = FULL_COUNT;
          state_d      = ST_REQUEST;
        end else if (flush) begin
          // Partial (possibly empty) block: it is always the last one.
          data_bytes_d  = fifo_count;
          blocks_left_d = 16'd1;
          state_d       = ST_REQUEST;
        end else begin
          state_d = ST_WAIT_DATA;
        end
      end
      ST_REQUEST: begin
        if (sd_ready) begin
          sd_wr_d    = 1'b1;
          byte_idx_d = 10'd0;
          state_d    = ST_STREAM;
        end else begin
          state_d = ST_REQUEST;
        end
      end
      ST_STREAM: begin
        if (sd_ready_for_next_byte) begin
          byte_idx_d = byte_idx_q + 10'd1;
          if (in_data_s && fifo_empty) begin
            underrun_d = 1'b1;
          end else begin
            underrun_d = underrun_q;
          end
          if (byte_idx_q == LAST_IDX) begin
            state_d = ST_WAIT_DONE;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_WAIT_DONE: begin
        // The controller's CRC/busy phase ends when sd_ready rises.
        if (sd_ready && !sd_ready_q) begin
          blocks_written_d = blocks_written_q + 16'd1;
          sd_addr_d        = sd_addr_q + 32'd1;
          blocks_left_d    = blocks_left_q - 16'd1;
          if (blocks_left_q == 16'd1) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_DATA;
          end
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      sd_addr_q        <= 32'd0;
      blocks_left_q    <= 16'd0;
      blocks_written_q <= 16'd0;
      data_bytes_q     <= 10'd0;
      byte_idx_q       <= 10'd0;
      underrun_q       <= 1'b0;
      sd_wr_q          <= 1'b0;
      done_q           <= 1'b0;
      sd_ready_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      sd_addr_q        <= sd_addr_d;
      blocks_left_q    <= blocks_left_d;
      blocks_written_q <= blocks_written_d;
      data_bytes_q     <= data_bytes_d;
      byte_idx_q       <= byte_idx_d;
      underrun_q       <= underrun_d;
      sd_wr_q          <= sd_wr_d;
      done_q           <= done_d;
      sd_ready_q       <= sd_ready;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign sd_wr          = sd_wr_q;
  assign sd_addr        = sd_addr_q;
  assign done           = done_q;
  assign underrun       = underrun_q;
  assign blocks_written = blocks_written_q;

endmodule

// File: tb/tb_sd_block_writer.sv
// Directed bench for sd_block_writer with a behavioural FWFT FIFO and a
// simple SD controller model pulsing sd_ready_for_next_byte every `gap` cycles.
module tb_sd_block_writer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] sector_addr;
  logic [15:0] n_blocks;
  logic        flush;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic [9:0]  fifo_count;
  logic        fifo_rd_en;
  logic        sd_ready;
  logic        sd_ready_for_next_byte;
  logic        sd_wr;
  logic [31:0] sd_addr;
  logic [7:0]  sd_din;
  logic        busy;
  logic        done;
  logic        underrun;
  logic [15:0] blocks_written;

  sd_block_writer #(.BLOCK_BYTES(512), .PAD_BYTE(8'h00)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .sector_addr           (sector_addr),
    .n_blocks              (n_blocks),
    .flush                 (flush),
    .fifo_data             (fifo_data),
    .fifo_empty            (fifo_empty),
    .fifo_count            (fifo_count),
    .fifo_rd_en            (fifo_rd_en),
    .sd_ready              (sd_ready),
    .sd_ready_for_next_byte(sd_ready_for_next_byte),
    .sd_wr                 (sd_wr),
    .sd_addr               (sd_addr),
    .sd_din                (sd_din),
    .busy                  (busy),
    .done                  (done),
    .underrun              (underrun),
    .blocks_written        (blocks_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  captured[$];
  logic [31:0] wr_addrs[$];
  int wr_count, done_count, pop_count, done_busy_err, early_wr_err;
  int cyc, first_wr_cyc;
  int c_state, gap, gap_cnt, bytes_pulled, busy_cnt, force_idx;
  bit saw_wr, got_pulse, popped;

  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0) ||
                 (force_idx >= 0 && c_state == 1 && sd_ready_for_next_byte && bytes_pulled == force_idx);
    fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'hEE;
    fifo_count = (fifo_q.size() > 1023) ? 10'd1023 : 10'(fifo_q.size());
  endtask

  task automatic clear_stats();
    captured.delete();
    wr_addrs.delete();
    wr_count = 0; done_count = 0; pop_count = 0; done_busy_err = 0; early_wr_err = 0;
    cyc = 0; first_wr_cyc = -1; force_idx = -1;
  endtask

  // One clock: sample outputs at negedge, then update FIFO and controller after posedge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    saw_wr = (sd_wr === 1'b1);
    if (saw_wr) begin
      wr_count++;
      wr_addrs.push_back(sd_addr);
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (c_state != 0) early_wr_err++;
    end
    if (done === 1'b1) begin
      done_count++;
      if (busy !== 1'b0) done_busy_err++;
    end
    got_pulse = (sd_ready_for_next_byte === 1'b1);
    if (got_pulse) captured.push_back(sd_din);
    popped = (fifo_rd_en === 1'b1);
    if (popped) pop_count++;
    @(posedge clk);
    #1;
    if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
    case (c_state)
      0: begin
        if (saw_wr) begin
          c_state = 1; sd_ready = 1'b0; gap_cnt = 0; bytes_pulled = 0;
        end
      end
      1: begin
        if (got_pulse) bytes_pulled++;
        if (bytes_pulled >= 512) begin
          c_state = 2; busy_cnt = 6; sd_ready_for_next_byte = 1'b0;
        end else begin
          gap_cnt++;
          if (gap_cnt >= gap) begin
            sd_ready_for_next_byte = 1'b1; gap_cnt = 0;
          end else begin
            sd_ready_for_next_byte = 1'b0;
          end
        end
      end
      2: begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          sd_ready = 1'b1; c_state = 0;
        end
      end
      default: c_state = 0;
    endcase
    drive_fifo();
  endtask

  task automatic start_xfer(input logic [31:0] addr, input logic [15:0] n);
    sector_addr = addr;
    n_blocks    = n;
    start       = 1'b1;
    cycle();
    start       = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input string name);
    int n0;
    int k;
    n0 = done_count;
    k = 0;
    while (done_count == n0 && k < budget) begin
      cycle();
      k++;
    end
    checks++;
    if (done_count == n0) begin
      errors++;
      $display("FAIL %s_timeout: no done after %0d cycles, required done pulse", name, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; sector_addr = 32'd0; n_blocks = 16'd0;
    sd_ready = 1'b1; sd_ready_for_next_byte = 1'b0;
    c_state = 0; gap = 4; fifo_q.delete(); clear_stats(); drive_fifo();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sd_wr !== 1'b0) begin errors++; $display("FAIL reset_sd_wr: got %b required 0", sd_wr); end
    checks++; if (sd_addr !== 32'd0) begin errors++; $display("FAIL reset_sd_addr: got %h required 0", sd_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b required 0", underrun); end
    checks++; if (blocks_written !== 16'd0) begin errors++; $display("FAIL reset_blocks_written: got %0d required 0", blocks_written); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_fifo_rd_en: got %b required 0", fifo_rd_en); end
    checks++; if (sd_din !== 8'h00) begin errors++; $display("FAIL reset_sd_din: got %h required 00", sd_din); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_single();
    int bad, first_bad;
    clear_stats(); gap = 4;
    for (int i = 0; i < 512; i++) fifo_q.push_back(8'(i));
    drive_fifo();
    start_xfer(32'h100, 16'd1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b required 1", busy); end
    run_until_done(4000, "single");
    checks++; if (first_wr_cyc < 3) begin errors++; $display("FAIL single_start_latency: sd_wr at cycle %0d required >= 3", first_wr_cyc); end
    checks++; if (wr_count != 1) begin errors++; $display("FAIL single_wr_count: got %0d required 1", wr_count); end
    checks++; if (wr_addrs.size() < 1 || wr_addrs[0] !== 32'h100) begin errors++; $display("FAIL single_addr: got %h required 00000100", (wr_addrs.size() > 0) ? wr_addrs[0] : 32'hx); end
    bad = 0; first_bad = -1;
    for (int k = 0; k < 512; k++) begin
      if (k >= captured.size() || captured[k] !== 8'(k)) begin bad++; if (first_bad < 0) first_bad = k; end
    end
    checks++; if (bad != 0 || captured.size() != 512) begin errors++; $display("FAIL single_data: %0d bad bytes (first %0d), %0d captured, required 0 bad of 512", bad, first_bad, captured.size()); end
    checks++; if (done_count != 1) begin errors++; $display("FAIL single_done: got %0d required 1", done_count); end
    checks++; if (blocks_written !== 16'd1) begin errors++; $display("FAIL single_blocks_written: got %0d required 1", blocks_written); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL single_underrun: got %b required 0", underrun); end
    checks++; if (pop_count != 512) begin errors++; $display("FAIL single_pops: got %0d required 512", pop_count); end
    checks++; if (done_busy_err != 0) begin errors++; $display("FAIL single_done_busy: %0d done cycles with busy high, required 0", done_busy_err); end
  endtask

  task automatic test_multi();
    int bad, first_bad, k;
    clear_stats(); gap = 4;
    for (int i = 0; i < 1536; i++) fifo_q.push_back(8'(i));
    drive_fifo();
    start_xfer(32'h100, 16'd3);
    k = 0;
    while (wr_count == 0 && k < 100) begin cycle(); k++; end
    // A start while busy must be ignored.
    sector_addr = 32'h999; n_blocks = 16'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    run_until_done(12000, "multi");
    checks++; if (wr_count != 3) begin errors++; $display("FAIL multi_wr_count: got %0d required 3", wr_count); end
    bad = 0;
    for (int j = 0; j < 3; j++) begin
      if (j >= wr_addrs.size() || wr_addrs[j] !== 32'h100 + 32'(j)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL multi_addrs: %0d wrong of 3, required 100/101/102", bad); end
    checks++; if (early_wr_err != 0) begin errors++; $display("FAIL multi_early_request: %0d sd_wr before sd_ready rose, required 0", early_wr_err); end
    bad = 0; first_bad = -1;
    for (int j = 0; j < 1536; j++) begin
      if (j >= captured.size() || captured[j] !== 8'(j)) begin bad++; if (first_bad < 0) first_bad = j; end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL multi_data: %0d bad bytes (first %0d), required 0", bad, first_bad); end
    checks++; if (blocks_written !== 16'd3) begin errors++; $display("FAIL multi_blocks_written: got %0d required 3", blocks_written); end
    checks++; if (sd_addr !== 32'h103) begin errors++; $display("FAIL multi_final_addr: got %h required 00000103", sd_addr); end
  endtask

  task automatic test_underrun();
    int bad, first_bad;
    logic [7:0] exp;
    clear_stats(); gap = 2;
    for (int i = 0; i < 512; i++) fifo_q.push_back(8'(i * 3 + 7));
    force_idx = 200;
    drive_fifo();
    start_xfer(32'h200, 16'd1);
    run_until_done(3000, "underrun");
    bad = 0; first_bad = -1;
    for (int k = 0; k < 512; k++) begin
      if (k < 200) exp = 8'(k * 3 + 7);
      else if (k == 200) exp = 8'h00;
      else exp = 8'((k - 1) * 3 + 7);
      if (k >= captured.size() || captured[k] !== exp) begin bad++; if (first_bad < 0) first_bad = k; end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL underrun_data: %0d bad bytes (first %0d), required 0", bad, first_bad); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_flag: got %b required 1", underrun); end
    checks++; if (pop_count != 511) begin errors++; $display("FAIL underrun_pops: got %0d required 511", pop_count); end
    force_idx = -1;
    repeat (10) cycle();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b required 1", underrun); end
    fifo_q.delete(); drive_fifo();
  endtask

  task automatic test_flush();
    int bad, first_bad;
    logic [7:0] exp;
    clear_stats(); gap = 3;
    for (int i = 0; i < 100; i++) fifo_q.push_back(8'(i + 64));
    flush = 1'b1;
    drive_fifo();
    start_xfer(32'h300, 16'd4);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL flush_underrun_cleared: got %b required 0", underrun); end
    run_until_done(3000, "flush");
    flush = 1'b0;
    bad = 0; first_bad = -1;
    for (int k = 0; k < 512; k++) begin
      exp = (k < 100) ? 8'(k + 64) : 8'h00;
      if (k >= captured.size() || captured[k] !== exp) begin bad++; if (first_bad < 0) first_bad = k; end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL flush_data: %0d bad bytes (first %0d), required 0", bad, first_bad); end
    checks++; if (wr_count != 1) begin errors++; $display("FAIL flush_wr_count: got %0d required 1", wr_count); end
    checks++; if (blocks_written !== 16'd1) begin errors++; $display("FAIL flush_blocks_written: got %0d required 1", blocks_written); end
    checks++; if (pop_count != 100) begin errors++; $display("FAIL flush_pops: got %0d required 100", pop_count); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL flush_underrun: got %b required 0", underrun); end
  endtask

  task automatic test_back_to_back();
    int bad, first_bad;
    clear_stats(); gap = 1;
    for (int i = 0; i < 512; i++) fifo_q.push_back(8'(255 - (i % 256)));
    drive_fifo();
    start_xfer(32'hFFFF_FFFF, 16'd0);
    run_until_done(2000, "b2b");
    checks++; if (wr_count != 1 || wr_addrs.size() < 1 || wr_addrs[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_wr: %0d sd_wr, required 1 at ffffffff", wr_count); end
    bad = 0; first_bad = -1;
    for (int k = 0; k < 512; k++) begin
      if (k >= captured.size() || captured[k] !== 8'(255 - (k % 256))) begin bad++; if (first_bad < 0) first_bad = k; end
    end
    checks++; if (bad != 0 || captured.size() != 512) begin errors++; $display("FAIL b2b_data: %0d bad (first %0d), %0d captured, required 0 bad of 512", bad, first_bad, captured.size()); end
    checks++; if (pop_count != 512) begin errors++; $display("FAIL b2b_pops: got %0d required 512", pop_count); end
    checks++; if (sd_addr !== 32'd0) begin errors++; $display("FAIL b2b_addr_wrap: got %h required 00000000", sd_addr); end
    checks++; if (blocks_written !== 16'd1) begin errors++; $display("FAIL b2b_blocks_written: got %0d required 1", blocks_written); end
  endtask

  task automatic test_reset_mid_stream();
    int k, d0;
    clear_stats(); gap = 2;
    for (int i = 0; i < 512; i++) fifo_q.push_back(8'(i));
    drive_fifo();
    start_xfer(32'h400, 16'd2);
    k = 0;
    while (!(c_state == 1 && bytes_pulled >= 300) && k < 2000) begin cycle(); k++; end
    checks++; if (!(c_state == 1 && bytes_pulled >= 300)) begin errors++; $display("FAIL rstmid_reach: pulled %0d bytes, required 300", bytes_pulled); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b required 0", done); end
    rst = 1'b0;
    c_state = 0; sd_ready = 1'b1; sd_ready_for_next_byte = 1'b0;
    fifo_q.delete(); drive_fifo();
    d0 = done_count;
    repeat (5) cycle();
    checks++; if (done_count != d0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: done pulses %0d busy %b, required 0 and 0", done_count - d0, busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_underrun();
    test_flush();
    test_back_to_back();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
